// File: rtl/mbist_fail_logger.sv
// MBIST fail logger: captures failing compares of a march run into a FWFT FIFO with
// a saturating error count, sticky overflow and pass/fail. Optional: MBIST_FAIL_LOG_FIRST_EN.
module mbist_fail_logger #(
  parameter int AWIDTH = 4,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              test_start,
  input  logic              test_done,
  input  logic              cmp_valid,
  input  logic              cmp_fail,
  input  logic [AWIDTH-1:0] cmp_addr,
  input  logic [2:0]        cmp_elem,
  input  logic              cmp_exp,
  input  logic              log_rd,
  output logic              log_valid,
  output logic [AWIDTH-1:0] log_addr,
  output logic [2:0]        log_elem,
  output logic              log_exp,
  output logic [CNT_W-1:0]  err_cnt,
  output logic              overflow,
  output logic              busy,
  output logic              done,
`ifdef MBIST_FAIL_LOG_FIRST_EN
  output logic [AWIDTH-1:0] first_addr,
  output logic [2:0]        first_elem,
`endif
  output logic              bist_status
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  typedef struct packed {
    logic [AWIDTH-1:0] addr;
    logic [2:0]        elem;
    logic              exp;
  } rec_t;

  state_e           state_q, state_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]      count_q, count_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic             ovf_q, ovf_d;
  logic             status_q, status_d;
  rec_t             mem_q [DEPTH];
  rec_t             head;

  logic accept_start, capture, pop, full, push, drop;

  always_comb begin
    state_d      = state_q;
    accept_start = 1'b0;
    capture      = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (test_start) begin
          state_d      = S_RUN;
          accept_start = 1'b1;
        end
      end
      S_RUN: begin
        // A fail arriving with test_done still belongs to this run.
        capture = cmp_valid && cmp_fail;
        if (test_done) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign full = (count_q == FULL_CNT);
  assign pop  = log_rd && (count_q != '0);
  assign push = capture && (!full || pop);
  assign drop = capture && full && !pop;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    err_d    = err_q;
    ovf_d    = ovf_q;
    status_d = status_q;
    if (accept_start) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      err_d    = '0;
      ovf_d    = 1'b0;
      status_d = 1'b0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + (PW+1)'(push) - (PW+1)'(pop);
      if (capture && (err_q != '1)) err_d = err_q + CNT_W'(1);
      if (drop)    ovf_d    = 1'b1;
      if (capture) status_d = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values; next-state logic above uses blocking assignments in always_comb.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= '0;
      ovf_q    <= 1'b0;
      status_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      err_q    <= err_d;
      ovf_q    <= ovf_d;
      status_q <= status_d;
    end
  end

  // NOTE: the log storage is deliberately not reset; its contents are only visible
  // through log_valid-gated outputs, so reset costs nothing functionally.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= '{addr: cmp_addr, elem: cmp_elem, exp: cmp_exp};
  end

  assign head        = mem_q[rd_ptr_q];
  assign log_valid   = (count_q != '0);
  assign log_addr    = log_valid ? head.addr : '0;
  assign log_elem    = log_valid ? head.elem : '0;
  assign log_exp     = log_valid ? head.exp  : 1'b0;
  assign err_cnt     = err_q;
  assign overflow    = ovf_q;
  assign bist_status = status_q;
  assign busy        = (state_q == S_RUN);
  assign done        = (state_q == S_DONE);

`ifdef MBIST_FAIL_LOG_FIRST_EN
  logic [AWIDTH-1:0] first_addr_q, first_addr_d;
  logic [2:0]        first_elem_q, first_elem_d;

  // status_q low means no fail has been captured yet in this run.
  always_comb begin
    first_addr_d = first_addr_q;
    first_elem_d = first_elem_q;
    if (accept_start) begin
      first_addr_d = '0;
      first_elem_d = '0;
    end else if (capture && !status_q) begin
      first_addr_d = cmp_addr;
      first_elem_d = cmp_elem;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      first_addr_q <= '0;
      first_elem_q <= '0;
    end else begin
      first_addr_q <= first_addr_d;
      first_elem_q <= first_elem_d;
    end
  end

  assign first_addr = first_addr_q;
  assign first_elem = first_elem_q;
`endif

endmodule

// File: tb/tb_mbist_fail_logger.sv
// Self-checking bench for mbist_fail_logger (AWIDTH=4, DEPTH=8, CNT_W=4):
// a vector table for a basic run plus directed sequences for FIFO/counter corners.
module tb_mbist_fail_logger;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       test_start = 1'b0, test_done = 1'b0;
  logic       cmp_valid = 1'b0, cmp_fail = 1'b0, cmp_exp = 1'b0;
  logic [3:0] cmp_addr = '0;
  logic [2:0] cmp_elem = '0;
  logic       log_rd = 1'b0;
  logic       log_valid, log_exp, overflow, busy, done, bist_status;
  logic [3:0] log_addr, err_cnt;
  logic [2:0] log_elem;
`ifdef MBIST_FAIL_LOG_FIRST_EN
  logic [3:0] first_addr;
  logic [2:0] first_elem;
`endif

  int checks = 0;
  int errors = 0;

  mbist_fail_logger #(.AWIDTH(4), .DEPTH(8), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .test_start(test_start), .test_done(test_done),
    .cmp_valid(cmp_valid), .cmp_fail(cmp_fail), .cmp_addr(cmp_addr),
    .cmp_elem(cmp_elem), .cmp_exp(cmp_exp), .log_rd(log_rd),
    .log_valid(log_valid), .log_addr(log_addr), .log_elem(log_elem), .log_exp(log_exp),
    .err_cnt(err_cnt), .overflow(overflow), .busy(busy), .done(done),
`ifdef MBIST_FAIL_LOG_FIRST_EN
    .first_addr(first_addr), .first_elem(first_elem),
`endif
    .bist_status(bist_status)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       start, tdone, valid, fail;
    logic [3:0] addr;
    logic [2:0] elem;
    logic       exp, rd;
    logic       e_valid;
    logic [3:0] e_addr;
    logic [2:0] e_elem;
    logic       e_exp;
    logic [3:0] e_cnt;
    logic       e_ovf, e_busy, e_done, e_status;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    test_start = 1'b0; test_done = 1'b0; cmp_valid = 1'b0; cmp_fail = 1'b0;
    cmp_addr = '0; cmp_elem = '0; cmp_exp = 1'b0; log_rd = 1'b0;
  endtask

  task automatic set_cmp(input logic v, input logic f, input logic [3:0] a,
                         input logic [2:0] e, input logic x);
    cmp_valid = v; cmp_fail = f; cmp_addr = a; cmp_elem = e; cmp_exp = x;
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".log_valid"}, 32'(log_valid), 0);
    check({tag, ".log_addr"}, 32'(log_addr), 0);
    check({tag, ".log_elem"}, 32'(log_elem), 0);
    check({tag, ".log_exp"}, 32'(log_exp), 0);
    check({tag, ".err_cnt"}, 32'(err_cnt), 0);
    check({tag, ".overflow"}, 32'(overflow), 0);
    check({tag, ".busy"}, 32'(busy), 0);
    check({tag, ".done"}, 32'(done), 0);
    check({tag, ".bist_status"}, 32'(bist_status), 0);
  endtask

  initial begin
    // start,tdone,valid,fail,addr,elem,exp,rd | valid,addr,elem,exp,cnt,ovf,busy,done,status
    vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd0,  3'd0, 1'b0, 1'b0,
                1'b0, 4'd0,  3'd0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 1'b0, 1'b1, 1'b1, 4'd3,  3'd1, 1'b0, 1'b0,
                1'b1, 4'd3,  3'd1, 1'b0, 4'd1, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 4'd5,  3'd2, 1'b1, 1'b0,
                1'b1, 4'd3,  3'd1, 1'b0, 4'd1, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[3] = '{1'b0, 1'b0, 1'b1, 1'b1, 4'd12, 3'd4, 1'b1, 1'b0,
                1'b1, 4'd3,  3'd1, 1'b0, 4'd2, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[4] = '{1'b0, 1'b1, 1'b0, 1'b0, 4'd0,  3'd0, 1'b0, 1'b0,
                1'b1, 4'd3,  3'd1, 1'b0, 4'd2, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd0,  3'd0, 1'b0, 1'b1,
                1'b1, 4'd12, 3'd4, 1'b1, 4'd2, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd0,  3'd0, 1'b0, 1'b1,
                1'b0, 4'd0,  3'd0, 1'b0, 4'd2, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd0,  3'd0, 1'b0, 1'b1,
                1'b0, 4'd0,  3'd0, 1'b0, 4'd2, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[8] = '{1'b0, 1'b0, 1'b1, 1'b1, 4'd9,  3'd3, 1'b1, 1'b0,
                1'b0, 4'd0,  3'd0, 1'b0, 4'd2, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[9] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd0,  3'd0, 1'b0, 1'b0,
                1'b0, 4'd0,  3'd0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0};

    // Reset state
    #2;
    check_zero("reset");
    tick();
    rst = 1'b1;

    // Basic run from the table: two fails logged, drained in order
    for (int i = 0; i < 10; i++) begin
      test_start = vecs[i].start; test_done = vecs[i].tdone;
      set_cmp(vecs[i].valid, vecs[i].fail, vecs[i].addr, vecs[i].elem, vecs[i].exp);
      log_rd = vecs[i].rd;
      tick();
      check($sformatf("v%0d.log_valid", i), 32'(log_valid), 32'(vecs[i].e_valid));
      check($sformatf("v%0d.log_addr", i), 32'(log_addr), 32'(vecs[i].e_addr));
      check($sformatf("v%0d.log_elem", i), 32'(log_elem), 32'(vecs[i].e_elem));
      check($sformatf("v%0d.log_exp", i), 32'(log_exp), 32'(vecs[i].e_exp));
      check($sformatf("v%0d.err_cnt", i), 32'(err_cnt), 32'(vecs[i].e_cnt));
      check($sformatf("v%0d.overflow", i), 32'(overflow), 32'(vecs[i].e_ovf));
      check($sformatf("v%0d.busy", i), 32'(busy), 32'(vecs[i].e_busy));
      check($sformatf("v%0d.done", i), 32'(done), 32'(vecs[i].e_done));
      check($sformatf("v%0d.status", i), 32'(bist_status), 32'(vecs[i].e_status));
    end
    clear_in();

    // Reset mid-RUN with three records logged
    for (int i = 0; i < 3; i++) begin
      set_cmp(1'b1, 1'b1, 4'(i + 1), 3'(i), 1'b1);
      tick();
    end
    clear_in();
    check("midrun.log_valid_pre", 32'(log_valid), 1);
    #2 rst = 1'b0;
    #1 check_zero("midrun_rst");
    tick();
    check_zero("midrun_idle");
    rst = 1'b1;
    set_cmp(1'b1, 1'b1, 4'd5, 3'd5, 1'b1);
    tick();
    check("idle_ignore.err_cnt", 32'(err_cnt), 0);
    check("idle_ignore.log_valid", 32'(log_valid), 0);
    clear_in();

    // All-passing run
    test_start = 1'b1; tick(); test_start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      set_cmp(1'b1, 1'b0, 4'(i), 3'(i % 8), 1'(i % 2));
      tick();
    end
    clear_in();
    test_done = 1'b1; tick(); test_done = 1'b0;
    check("pass.err_cnt", 32'(err_cnt), 0);
    check("pass.status", 32'(bist_status), 0);
    check("pass.overflow", 32'(overflow), 0);
    check("pass.log_valid", 32'(log_valid), 0);
    check("pass.done", 32'(done), 1);

    // Fill to full, then pop+push at full: no overflow, count stays at DEPTH
    test_start = 1'b1; tick(); test_start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      set_cmp(1'b1, 1'b1, 4'(i), 3'(i % 8), 1'(i % 2));
      tick();
    end
    clear_in();
    check("full.overflow", 32'(overflow), 0);
    check("full.err_cnt", 32'(err_cnt), 8);
    set_cmp(1'b1, 1'b1, 4'd8, 3'd0, 1'b0);
    log_rd = 1'b1;
    tick();
    clear_in();
    check("fullpp.overflow", 32'(overflow), 0);
    check("fullpp.err_cnt", 32'(err_cnt), 9);
    for (int i = 1; i <= 8; i++) begin
      check($sformatf("fullpp.valid%0d", i), 32'(log_valid), 1);
      check($sformatf("fullpp.addr%0d", i), 32'(log_addr), 32'(i));
      check($sformatf("fullpp.elem%0d", i), 32'(log_elem), 32'(i % 8));
      log_rd = 1'b1; tick(); log_rd = 1'b0;
    end
    check("fullpp.empty", 32'(log_valid), 0);

    // Ten fails without reads: first eight kept, overflow set
    test_done = 1'b1; tick(); test_done = 1'b0;
    test_start = 1'b1; tick(); test_start = 1'b0;
    check("ovf_run.cleared_ovf", 32'(overflow), 0);
    for (int i = 0; i < 10; i++) begin
      set_cmp(1'b1, 1'b1, 4'(i), 3'(i % 8), 1'(i % 2));
      tick();
    end
    clear_in();
    check("ovf.err_cnt", 32'(err_cnt), 10);
    check("ovf.overflow", 32'(overflow), 1);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("ovf.valid%0d", i), 32'(log_valid), 1);
      check($sformatf("ovf.addr%0d", i), 32'(log_addr), 32'(i));
      check($sformatf("ovf.exp%0d", i), 32'(log_exp), 32'(i % 2));
      log_rd = 1'b1; tick(); log_rd = 1'b0;
    end
    check("ovf.empty", 32'(log_valid), 0);
    check("ovf.sticky", 32'(overflow), 1);

    // Saturation at 15 and test_start ignored in RUN
    test_done = 1'b1; tick(); test_done = 1'b0;
    test_start = 1'b1; tick(); test_start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      set_cmp(1'b1, 1'b1, 4'(i), 3'(i % 8), 1'b0);
      tick();
    end
    clear_in();
    check("sat.err_cnt", 32'(err_cnt), 15);
    check("sat.status", 32'(bist_status), 1);
    test_start = 1'b1; tick(); test_start = 1'b0;
    check("start_in_run.err_cnt", 32'(err_cnt), 15);
    check("start_in_run.overflow", 32'(overflow), 1);
    check("start_in_run.busy", 32'(busy), 1);
    check("start_in_run.log_valid", 32'(log_valid), 1);

    // Fail on the test_done cycle is logged; fail in DONE is not
    test_done = 1'b1; tick(); test_done = 1'b0;
    test_start = 1'b1; tick(); test_start = 1'b0;
    set_cmp(1'b1, 1'b1, 4'd6, 3'd5, 1'b1);
    test_done = 1'b1;
    tick();
    clear_in();
    check("donefail.done", 32'(done), 1);
    check("donefail.err_cnt", 32'(err_cnt), 1);
    check("donefail.log_valid", 32'(log_valid), 1);
    check("donefail.log_addr", 32'(log_addr), 6);
    check("donefail.log_elem", 32'(log_elem), 5);
    check("donefail.log_exp", 32'(log_exp), 1);
    set_cmp(1'b1, 1'b1, 4'd10, 3'd2, 1'b0);
    tick();
    clear_in();
    check("indone.err_cnt", 32'(err_cnt), 1);
    log_rd = 1'b1; tick(); log_rd = 1'b0;
    check("indone.empty", 32'(log_valid), 0);

`ifdef MBIST_FAIL_LOG_FIRST_EN
    // First-fail capture survives later fails and clears on the next start
    test_start = 1'b1; tick(); test_start = 1'b0;
    set_cmp(1'b1, 1'b1, 4'd7, 3'd2, 1'b0); tick();
    set_cmp(1'b1, 1'b1, 4'd2, 3'd6, 1'b1); tick();
    clear_in();
    test_done = 1'b1; tick(); test_done = 1'b0;
    check("first.addr", 32'(first_addr), 7);
    check("first.elem", 32'(first_elem), 2);
    test_start = 1'b1; tick(); test_start = 1'b0;
    check("first.clr_addr", 32'(first_addr), 0);
    check("first.clr_elem", 32'(first_elem), 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
